// File: rtl/padded_pixel_streamer_pkg.sv
// Shared geometry helpers, default frame dimensions and FSM encoding for the
// padded pixel streamer.
package padded_pixel_streamer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_e;

   // Padded extent of one image dimension: the border is added on both sides.
   function automatic int padded_dim(input int dim, input int pad);
      return dim + 2 * pad;
   endfunction

   localparam int DEF_IMG_W = 480;
   localparam int DEF_IMG_H = 480;
   localparam int DEF_PAD   = 1;
   localparam int DEF_PW    = padded_dim(DEF_IMG_W, DEF_PAD);
   localparam int DEF_PH    = padded_dim(DEF_IMG_H, DEF_PAD);

endpackage

// File: rtl/padded_pixel_streamer_coord.sv
// Row/column walker over the padded frame. Flags whether the current
// coordinate lies inside the unpadded image and whether it is the final pixel.
module pad_coord_counter
   import padded_pixel_streamer_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W,
   parameter int IMG_H = DEF_IMG_H,
   parameter int PAD   = DEF_PAD
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic interior,
   output logic last_pix
);

   localparam int PW = padded_dim(IMG_W, PAD);
   localparam int PH = padded_dim(IMG_H, PAD);
   localparam int CW = $clog2(PW);
   localparam int RW = $clog2(PH);

   localparam logic [CW-1:0] COL_LO   = CW'(PAD);
   localparam logic [CW-1:0] COL_HI   = CW'(PAD + IMG_W);
   localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);
   localparam logic [RW-1:0] ROW_LO   = RW'(PAD);
   localparam logic [RW-1:0] ROW_HI   = RW'(PAD + IMG_H);
   localparam logic [RW-1:0] ROW_LAST = RW'(PH - 1);

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   // Next coordinate: column wraps into the next row; the row wraps after the
   // final line so the walker is back at the origin when a frame ends.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clr) begin
         col_d = '0;
         row_d = '0;
      end else if (en) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Coordinate registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

   assign interior = (row_q >= ROW_LO) && (row_q < ROW_HI) &&
                     (col_q >= COL_LO) && (col_q < COL_HI);
   assign last_pix = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/padded_pixel_streamer.sv
// Streams an IMG_W x IMG_H feature map out of a synchronous BRAM as a
// row-major pixel stream surrounded by a PAD-wide zero border.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; outputs quiet
// STREAM | issuing one padded coordinate per unstalled cycle
// DONE   | last pixel emerging on dout; done pulses on the way back to IDLE
module padded_pixel_streamer
   import padded_pixel_streamer_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int PAD    = DEF_PAD,
   parameter int ADDR_W = 18
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stall,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic [WIDTH-1:0]  dout,
   output logic              valid_out,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
   logic [ADDR_W-1:0] addr_hold_q, addr_hold_d;
   logic              valid_q, valid_d;
   logic              pix_int_q, pix_int_d;
   logic              done_q, done_d;
   logic              clr;
   logic              issue;
   logic              rd;
   logic              interior;
   logic              last_pix;

   pad_coord_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .PAD   (PAD)
   ) u_coord (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .en       (issue),
      .interior (interior),
      .last_pix (last_pix)
   );

   // Next-state logic. The cycle carrying done is already IDLE, so start is
   // masked by done_q to keep a start coincident with done from launching.
   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !done_q) begin
               state_d = STREAM;
               clr     = 1'b1;
            end
         end
         STREAM: begin
            issue = !stall;
            if (issue && last_pix) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign rd = issue && interior;

   // Address generation and output-stage flags. addr_hold keeps mem_addr
   // steady across border pixels and stalls.
   always_comb begin
      addr_cnt_d  = addr_cnt_q;
      addr_hold_d = addr_hold_q;
      if (clr) begin
         addr_cnt_d = '0;
      end else if (rd) begin
         addr_cnt_d  = addr_cnt_q + ADDR_W'(1);
         addr_hold_d = addr_cnt_q;
      end
      valid_d   = issue;
      pix_int_d = rd;
      done_d    = (state_q == DONE);
   end

   // State, address and output-stage registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_cnt_q  <= '0;
         addr_hold_q <= '0;
         valid_q     <= 1'b0;
         pix_int_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_cnt_q  <= addr_cnt_d;
         addr_hold_q <= addr_hold_d;
         valid_q     <= valid_d;
         pix_int_q   <= pix_int_d;
         done_q      <= done_d;
      end
   end

   assign mem_rd_en = rd;
   assign mem_addr  = rd ? addr_cnt_q : addr_hold_q;
   assign dout      = pix_int_q ? mem_rdata : '0;
   assign valid_out = valid_q;
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

endmodule

// File: tb/tb_padded_pixel_streamer.sv
// Directed bench for padded_pixel_streamer on a 4x3 image with a 1-pixel
// border (6x5 padded, 30 pixels, 12 BRAM reads).
module tb_padded_pixel_streamer;

   localparam int W    = 8;
   localparam int IW   = 4;
   localparam int IH   = 3;
   localparam int PD   = 1;
   localparam int AW   = 4;
   localparam int PWD  = IW + 2 * PD;
   localparam int PHT  = IH + 2 * PD;
   localparam int NPIX = PWD * PHT;
   localparam int NRD  = IW * IH;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          stall = 1'b0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_rdata;
   logic [W-1:0]  dout;
   logic          valid_out;
   logic          busy;
   logic          done;

   int n_chk = 0;
   int n_fail = 0;
   int cyc_cnt = 0;
   int rd_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int cap_dout[$];
   int cap_cyc[$];
   int rd_addr[$];
   int exp_pix[NPIX];
   bit launched = 1'b0;

   padded_pixel_streamer #(
      .WIDTH  (W),
      .IMG_W  (IW),
      .IMG_H  (IH),
      .PAD    (PD),
      .ADDR_W (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stall     (stall),
      .mem_rd_en (mem_rd_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .dout      (dout),
      .valid_out (valid_out),
      .busy      (busy),
      .done      (done)
   );

   initial forever #5 clk = ~clk;

   // BRAM model: word at address a holds a+1.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= W'(mem_addr) + W'(1);
   end

   initial forever begin
      @(posedge clk);
      cyc_cnt = cyc_cnt + 1;
   end

   // Capture outputs mid-cycle.
   initial forever begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
         cap_dout.push_back(int'(dout));
         cap_cyc.push_back(cyc_cnt);
      end
      if (mem_rd_en === 1'b1) begin
         rd_addr.push_back(int'(mem_addr));
         rd_cnt = rd_cnt + 1;
      end
      if (done === 1'b1) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc_cnt;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk = n_chk + 1;
      if (obs !== exp_v) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // One frame: optional stall windows (cycle offsets from the start cycle),
   // optional stray starts mid-frame and in the done cycle, optional start in
   // the cycle after done to chain the next frame.
   task automatic run_frame(input string nm, input int s0, input int l0,
                            input int s1, input int l1, input bit mid_st,
                            input bit done_st, input bit chain, input int exp_lat);
      int s, bv, brd, bd, nv, nr;
      bit got;
      logic busy_mid;
      if (!launched) begin
         @(posedge clk); #1;
         start = 1'b1;
      end
      launched = 1'b0;
      s = cyc_cnt;
      bv = cap_dout.size();
      brd = rd_cnt;
      bd = done_cnt;
      got = 1'b0;
      busy_mid = 1'b0;
      for (int k = 1; k < 100; k++) begin
         @(posedge clk); #1;
         start = (mid_st && k == 10) || (done_st && done === 1'b1);
         stall = (k >= s0 && k < s0 + l0) || (k >= s1 && k < s1 + l1);
         if (k == 5) busy_mid = busy;
         if (done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      @(posedge clk); #1;
      start = chain;
      stall = 1'b0;
      launched = chain;

      chk({nm, "_done_seen"}, 32'(got), 1);
      chk({nm, "_busy_mid"}, 32'(busy_mid), 1);
      chk({nm, "_busy_after"}, 32'(busy), 0);
      nv = cap_dout.size() - bv;
      nr = rd_cnt - brd;
      chk({nm, "_valid_cnt"}, nv, NPIX);
      for (int i = 0; i < NPIX; i++) begin
         if (i < nv) chk($sformatf("%s_pix%0d", nm, i), cap_dout[bv + i], exp_pix[i]);
      end
      if (nv >= NPIX) begin
         chk({nm, "_first_lat"}, cap_cyc[bv] - s, 2);
         chk({nm, "_done_after_last"}, done_cyc - cap_cyc[bv + NPIX - 1], 1);
         if (l0 > 0) chk({nm, "_gap0"}, cap_cyc[bv + 8] - cap_cyc[bv + 7], l0 + 1);
         if (l1 > 0) chk({nm, "_gap1"}, cap_cyc[bv + 21] - cap_cyc[bv + 20], l1 + 1);
      end
      chk({nm, "_done_lat"}, done_cyc - s, exp_lat);
      chk({nm, "_done_cnt"}, done_cnt - bd, 1);
      chk({nm, "_rd_cnt"}, nr, NRD);
      if (nr >= NRD) begin
         chk({nm, "_addr_first"}, rd_addr[brd], 0);
         chk({nm, "_addr_last"}, rd_addr[brd + NRD - 1], NRD - 1);
      end
   endtask

   initial begin
      int bv, bd, nidle;
      for (int r = 0; r < PHT; r++) begin
         for (int c = 0; c < PWD; c++) begin
            if (r >= PD && r < PD + IH && c >= PD && c < PD + IW)
               exp_pix[r * PWD + c] = (r - PD) * IW + (c - PD) + 1;
            else
               exp_pix[r * PWD + c] = 0;
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(valid_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_rd_en", 32'(mem_rd_en), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_dout", 32'(dout), 0);
      rst_n = 1'b1;

      run_frame("plain", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32);
      run_frame("stall", 9, 3, 25, 1, 1'b0, 1'b0, 1'b0, 36);
      run_frame("stray", 0, 0, 0, 0, 1'b1, 1'b1, 1'b1, 32);
      run_frame("chain", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32);

      // Abort mid-frame with reset.
      @(posedge clk); #1;
      start = 1'b1;
      bv = cap_dout.size();
      bd = done_cnt;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (cap_dout.size() - bv >= 15) break;
      end
      chk("abort_reached15", 32'(cap_dout.size() - bv >= 15), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(valid_out), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_rd_en", 32'(mem_rd_en), 0);
      chk("abort_addr", 32'(mem_addr), 0);
      chk("abort_dout", 32'(dout), 0);
      chk("abort_done", 32'(done), 0);
      repeat (3) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt - bd, 0);
      rst_n = 1'b1;

      run_frame("after_rst", 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32);

      bv = cap_dout.size();
      repeat (10) @(posedge clk);
      #1;
      nidle = cap_dout.size() - bv;
      chk("idle_no_valid", nidle, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/padded_pixel_streamer.md
Name: padded_pixel_streamer

Overview:
- Transmit-side source for the line buffers. Reads an IMG_W x IMG_H feature map from a synchronous single-port BRAM.
- Emits it as a row-major pixel stream with a PAD-pixel zero border: row width IMG_W+2*PAD (482 by default), IMG_H+2*PAD rows.
- Drives the din/valid_in pair of the line-buffer chain and window generator.
- Control is a start/busy/done handshake, plus a stall input to pause the stream.

Parameters:
- WIDTH, 8, pixel bit width.
- IMG_W, 480, unpadded image width.
- IMG_H, 480, unpadded image height.
- PAD, 1, zero-border thickness on every side.
- ADDR_W, 18, BRAM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle frame start request.
- stall  input  1  when high, no new pixel is issued this cycle.
- mem_rd_en  output  1  BRAM read enable.
- mem_addr  output  ADDR_W  BRAM read address.
- mem_rdata  input  WIDTH  BRAM read data, valid 1 cycle after mem_rd_en.
- dout  output  WIDTH  padded pixel.
- valid_out  output  1  dout valid; drives valid_in downstream.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset: state IDLE; row/col counters 0; address counter 0; mem_rd_en, mem_addr, dout, valid_out, busy and done all 0. Reset mid-frame aborts immediately with no done pulse.
- Geometry: PW = IMG_W+2*PAD, PH = IMG_H+2*PAD.
  - col counts 0..PW-1, then wraps to 0 and increments row.
  - row counts 0..PH-1.
- FSM has three states: IDLE, STREAM, DONE.
- IDLE:
  - start=1 moves to STREAM next cycle with row=col=0 and busy=1.
  - start is ignored in every state other than IDLE.
- STREAM, issue stage (stage 0), each cycle with stall=0:
  - Issues coordinate (row,col) and advances the counters.
  - Interior means PAD<=row<PAD+IMG_H and PAD<=col<PAD+IMG_W.
  - Interior: mem_rd_en=1 and mem_addr=address counter; the address counter then increments by 1. No multiplier; addresses run 0..IMG_W*IMG_H-1 in order.
  - Border: mem_rd_en=0 and mem_addr holds its value.
- STREAM, output stage (stage 1): registered one cycle after issue.
  - valid_out=1.
  - dout = mem_rdata for an interior pixel, 0 for a border pixel (a registered flag follows the pixel).
  - Issue-to-output latency is exactly 1 cycle. The first valid_out appears 2 cycles after the start cycle.
- stall=1:
  - Counters, address counter and mem_addr hold; mem_rd_en=0.
  - valid_out=0 the following cycle. A pixel already issued still emerges.
  - No pixel is lost or duplicated.
- Last pixel: on issue of (PH-1, PW-1), move to DONE.
- DONE:
  - The last pixel's valid_out is high in this cycle.
  - Next cycle: done=1 for one cycle, busy=0, state returns to IDLE.
  - start in the same cycle as done is ignored; start in the cycle after done is accepted.
- Frame totals:
  - Exactly PW*PH valid_out pulses per frame (482*482 = 232324 by default).
  - mem_rd_en pulses = IMG_W*IMG_H.
- Downstream has no backpressure. Upstream control guarantees pacing via stall.

Decomposition:
- Shared package holds the padded-geometry constants (PW, PH) derived from IMG_W/IMG_H/PAD, and the FSM state encoding (IDLE=2'd0, STREAM=2'd1, DONE=2'd2).
- One sub-module, pad_coord_counter: the row/col counters with enable and wrap, the interior flag and the last-pixel flag.
- The top level holds the FSM, address counter and output stage.

Test Plan:
- Small config IMG_W=4, IMG_H=3, PAD=1, BRAM model returns data = addr+1; single start -> 30 valid_out pulses:
  - row 0 all 0;
  - row 1 = 0,1,2,3,4,0;
  - row 3 = 0,9,10,11,12,0;
  - row 4 all 0;
  - done one cycle after the 30th pixel; 12 mem_rd_en pulses.
- Same config with stall high 3 cycles at pixel 8 and 1 cycle at pixel 21 -> identical 30-value sequence; valid_out gaps of 3 and 1 cycles; done delayed by 4 cycles.
- start re-asserted mid-frame and in the done cycle -> ignored; the frame stream is unchanged.
- start the cycle after done -> second frame identical; addresses restart at 0.
- rst_n low at pixel 15 -> all outputs 0 asynchronously; no done; a subsequent start produces a full correct frame.
- Default config (480x480, PAD=1) -> 232324 valid_out pulses, 230400 reads, last mem_addr 230399, then a single done.
